// File: rtl/jpeg_readout_if.sv
// jpeg_readout port bundle: encoder write bus, host controls and byte stream.
// master = encoder/host side, slave = image buffer.
interface jpeg_readout_if #(
  parameter int AW = 16
);
  logic [31:0]   wr_data_in;
  logic [AW-1:0] wr_address_in;
  logic          wr_valid_in;
  logic          image_valid_in;
  logic          start_in;
  logic          clear_in;
  logic          rd_ready_in;
  logic [7:0]    rd_byte_out;
  logic          rd_valid_out;
  logic          rd_last_out;
  logic [AW:0]   image_size_out;
  logic          image_ready_out;
  logic          busy_out;
  logic          overflow_out;

  modport master (
    output wr_data_in, wr_address_in, wr_valid_in,
    output image_valid_in, start_in, clear_in, rd_ready_in,
    input  rd_byte_out, rd_valid_out, rd_last_out,
    input  image_size_out, image_ready_out, busy_out, overflow_out
  );

  modport slave (
    input  wr_data_in, wr_address_in, wr_valid_in,
    input  image_valid_in, start_in, clear_in, rd_ready_in,
    output rd_byte_out, rd_valid_out, rd_last_out,
    output image_size_out, image_ready_out, busy_out, overflow_out
  );
endinterface

// File: rtl/jpeg_readout.sv
// JPEG image buffer: captures encoder words into a word RAM and
// replays the stored image as a valid/ready byte stream.
module jpeg_readout #(
  parameter int BUF_BYTES = 65536,
  parameter int AW        = 16
) (
  input logic          clk,
  input logic          reset,
  jpeg_readout_if.slave bus
);
  localparam int WORDS = BUF_BYTES / 4;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AW:0] BUF_L = (AW+1)'(BUF_BYTES);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  logic [1:0]  r_state;
  logic        r_iv;
  logic [AW:0] r_size;
  logic [AW:0] r_len;
  logic [AW:0] r_cnt;
  logic [AW:0] r_fetch;
  logic        r_ovf;
  logic [31:0] r_mem [WORDS];
  logic [31:0] r_q;
  logic [31:0] r_cur;
  logic [31:0] r_nxt;
  logic        r_q_v;
  logic        r_cur_v;
  logic        r_nxt_v;

  logic          w_iv_edge;
  logic [AW:0]   w_addr;
  logic          w_can_wr;
  logic          w_in_range;
  logic          w_we;
  logic          w_wr_err;
  logic          w_start;
  logic [AW:0]   w_nwords;
  logic          w_re;
  logic [WW-1:0] w_raddr;
  logic [WW-1:0] w_widx;
  logic          w_acc;
  logic          w_last;
  logic [1:0]    w_lane;

  assign w_iv_edge  = bus.image_valid_in & ~r_iv;
  assign w_addr     = {1'b0, bus.wr_address_in};
  assign w_can_wr   = (r_state == S_EMPTY) | (r_state == S_FILL);
  assign w_in_range = w_addr < BUF_L;
  assign w_we       = bus.wr_valid_in & w_can_wr & w_in_range
                    & ~bus.clear_in;
  assign w_wr_err   = bus.wr_valid_in & ~(w_can_wr & w_in_range);
  assign w_widx     = bus.wr_address_in[WW+1:2];
  assign w_start    = (r_state == S_READY) & bus.start_in;
  assign w_nwords   = (r_len + (AW+1)'(3)) >> 2;
  assign w_lane     = r_cnt[1:0];
  assign w_acc      = r_cur_v & bus.rd_ready_in;
  assign w_last     = r_cur_v & (r_cnt == r_len - 1'b1);

  // Word 0 is fetched on the start edge; later words only when the
  // prefetch slot and the RAM output are both free.
  assign w_re = w_start ? (r_len != '0)
              : (r_state == S_READ) & (r_fetch < w_nwords)
                & ~r_nxt_v & ~r_q_v;
  assign w_raddr = w_start ? '0 : r_fetch[WW-1:0];

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_widx] <= bus.wr_data_in;
    if (w_re) r_q <= r_mem[w_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_iv    <= 1'b0;
      r_size  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fetch <= '0;
      r_ovf   <= 1'b0;
      r_cur   <= '0;
      r_nxt   <= '0;
      r_q_v   <= 1'b0;
      r_cur_v <= 1'b0;
      r_nxt_v <= 1'b0;
    end else begin
      r_iv <= bus.image_valid_in;
      if (bus.clear_in) begin
        r_state <= S_EMPTY;
        r_size  <= '0;
        r_len   <= '0;
        r_ovf   <= 1'b0;
        r_q_v   <= 1'b0;
        r_cur_v <= 1'b0;
        r_nxt_v <= 1'b0;
      end else begin
        r_q_v <= w_re;
        if (w_wr_err) r_ovf <= 1'b1;
        unique case (r_state)
          S_EMPTY: begin
            if (w_iv_edge) begin
              r_state <= S_READY;
              r_size  <= '0;
              r_len   <= '0;
            end else if (bus.wr_valid_in) begin
              r_state <= S_FILL;
            end
          end
          S_FILL: begin
            if (w_iv_edge) begin
              r_state <= S_READY;
              r_size  <= w_addr;
              r_len   <= (w_addr > BUF_L) ? BUF_L : w_addr;
              if (w_addr > BUF_L) r_ovf <= 1'b1;
            end
          end
          S_READY: begin
            if (w_start) begin
              r_state <= S_READ;
              r_cnt   <= '0;
              r_fetch <= (r_len != '0) ? (AW+1)'(1) : '0;
              r_cur_v <= 1'b0;
              r_nxt_v <= 1'b0;
            end
          end
          S_READ: begin
            if (r_len == '0) r_state <= S_READY;
            if (w_re) r_fetch <= r_fetch + 1'b1;
            if (w_acc) r_cnt <= r_cnt + 1'b1;
            if (w_acc && w_last) begin
              r_state <= S_READY;
              r_cur_v <= 1'b0;
              r_nxt_v <= 1'b0;
            end else if (w_acc && w_lane == 2'd3) begin
              if (r_nxt_v) begin
                r_cur   <= r_nxt;
                r_nxt_v <= 1'b0;
              end else if (r_q_v) begin
                r_cur <= r_q;
              end else begin
                r_cur_v <= 1'b0;
              end
            end else if (r_q_v) begin
              if (!r_cur_v) begin
                r_cur   <= r_q;
                r_cur_v <= 1'b1;
              end else begin
                r_nxt   <= r_q;
                r_nxt_v <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.rd_byte_out     = r_cur[{w_lane, 3'b000} +: 8];
  assign bus.rd_valid_out    = r_cur_v;
  assign bus.rd_last_out     = w_last;
  assign bus.image_size_out  = r_size;
  assign bus.image_ready_out = (r_state == S_READY) | (r_state == S_READ);
  assign bus.busy_out        = (r_state == S_READ);
  assign bus.overflow_out    = r_ovf;
endmodule

// File: tb/tb_jpeg_readout.sv
// Bench for jpeg_readout: directed image scenarios plus random images,
// checked through a byte scoreboard fed by a behavioural buffer model.
module tb_jpeg_readout;
  localparam int BUF = 16;
  localparam int AW  = 6;
  localparam int M_EMPTY = 0;
  localparam int M_FILL  = 1;
  localparam int M_READY = 2;
  localparam int M_READ  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jpeg_readout_if #(.AW(AW)) bus ();
  jpeg_readout #(.BUF_BYTES(BUF), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] m_mem [BUF];
  int         m_state;
  int         m_size;
  bit         m_ovf;
  bit         m_ivp;
  logic [8:0] exp_q [$];

  int rmode = 0;
  int rcnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // host ready pattern: 0 always, 1 = 1,0,0 repeating, 2 random
  initial begin
    bus.rd_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rcnt++;
      case (rmode)
        0: bus.rd_ready_in = 1'b1;
        1: bus.rd_ready_in = (rcnt % 3 == 0);
        default: bus.rd_ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  bit         prev_stall = 1'b0;
  logic [8:0] prev_out;
  always @(negedge clk) begin
    logic [8:0] cur;
    logic [8:0] e;
    cur = {bus.rd_last_out, bus.rd_byte_out};
    if (bus.rd_valid_out === 1'b1) begin
      if (prev_stall) chk("hold", 32'(cur), 32'(prev_out));
      if (bus.rd_ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %0h want none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("byte", 32'(cur), 32'(e));
        end
      end
    end
    prev_stall = (bus.rd_valid_out === 1'b1) && !bus.rd_ready_in;
    prev_out   = cur;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic mwrite(input int addr, input logic [31:0] d);
    if (addr < BUF)
      for (int b = 0; b < 4; b++) m_mem[(addr & ~3) + b] = d[8*b +: 8];
    else
      m_ovf = 1'b1;
  endtask

  task automatic step(input bit wv, input int addr, input logic [31:0] d,
                      input bit iv, input bit st, input bit clr);
    bit edge_;
    int len;
    bus.wr_valid_in    = wv;
    bus.wr_address_in  = AW'(addr);
    bus.wr_data_in     = d;
    bus.image_valid_in = iv;
    bus.start_in       = st;
    bus.clear_in       = clr;
    edge_ = iv && !m_ivp;
    m_ivp = iv;
    if (clr) begin
      m_state = M_EMPTY;
      m_size  = 0;
      m_ovf   = 1'b0;
    end else begin
      case (m_state)
        M_EMPTY: begin
          if (wv) mwrite(addr, d);
          if (edge_) begin
            m_size  = 0;
            m_state = M_READY;
          end else if (wv) m_state = M_FILL;
        end
        M_FILL: begin
          if (wv) mwrite(addr, d);
          if (edge_) begin
            m_size  = addr;
            if (addr > BUF) m_ovf = 1'b1;
            m_state = M_READY;
          end
        end
        M_READY: begin
          if (wv) m_ovf = 1'b1;
          if (st) begin
            m_state = M_READ;
            len = (m_size > BUF) ? BUF : m_size;
            for (int i = 0; i < len; i++)
              exp_q.push_back({i == len - 1, m_mem[i]});
          end
        end
        default: if (wv) m_ovf = 1'b1;
      endcase
    end
    tick();
    if (clr) exp_q.delete();
    bus.wr_valid_in = 1'b0;
    bus.start_in    = 1'b0;
    bus.clear_in    = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_ovf"},   32'(bus.overflow_out),    32'(m_ovf));
    chk({tag, "_size"},  32'(bus.image_size_out),  32'(m_size));
    chk({tag, "_ready"}, 32'(bus.image_ready_out), 32'(m_state == M_READY));
    chk({tag, "_busy"},  32'(bus.busy_out),        32'(m_state == M_READ));
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy_out) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done"}, 32'(bus.busy_out), 32'd0);
    exp_q.delete();
    if (m_state == M_READ) m_state = M_READY;
    tick();
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_byte"},  32'(bus.rd_byte_out),     32'd0);
    chk({tag, "_vld"},   32'(bus.rd_valid_out),    32'd0);
    chk({tag, "_last"},  32'(bus.rd_last_out),     32'd0);
    chk({tag, "_size"},  32'(bus.image_size_out),  32'd0);
    chk({tag, "_ready"}, 32'(bus.image_ready_out), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy_out),        32'd0);
    chk({tag, "_ovf"},   32'(bus.overflow_out),    32'd0);
  endtask

  task automatic model_reset();
    m_state = M_EMPTY;
    m_size  = 0;
    m_ovf   = 1'b0;
    m_ivp   = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int nw;
    int sz;
    bit same;
    reset              = 1'b1;
    bus.wr_valid_in    = 1'b0;
    bus.wr_address_in  = '0;
    bus.wr_data_in     = '0;
    bus.image_valid_in = 1'b0;
    bus.start_in       = 1'b0;
    bus.clear_in       = 1'b0;
    model_reset();
    tick();
    chk_zero_outs("rst");
    tick();
    reset = 1'b0;

    // preload upper words so every stored byte is known
    step(1, 8,  32'h0b0a0908, 0, 0, 0);
    step(1, 12, 32'h0f0e0d0c, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk_status("pre");

    // basic image: exact latency and bubble-free stream
    step(1, 0, 32'h03020100, 0, 0, 0);
    step(1, 4, 32'h07060504, 0, 0, 0);
    step(0, 8, 0, 1, 0, 0);
    chk_status("t1_fin");
    step(0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("t1_lat1", 32'(bus.rd_valid_out), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_stream", 32'(bus.rd_valid_out), 32'd1);
    end
    @(negedge clk);
    chk("t1_vld_end", 32'(bus.rd_valid_out), 32'd0);
    wait_drain("t1");
    chk_status("t1");

    // re-read, then backpressure
    step(0, 0, 0, 1, 1, 0);
    wait_drain("t3_rr");
    rmode = 1;
    step(0, 0, 0, 1, 1, 0);
    wait_drain("t2_bp");
    rmode = 0;
    chk_status("t2");

    // write while READY is dropped and flagged
    step(1, 0, 32'hdeadbeef, 1, 0, 0);
    chk_status("t4_rdywr");
    step(0, 0, 0, 1, 1, 0);
    wait_drain("t4_rdywr");

    // zero-byte image
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    chk_status("t3_zero");
    step(0, 0, 0, 1, 1, 0);
    chk("t3_zero_busy", 32'(bus.busy_out), 32'd1);
    idle(3);
    chk("t3_zero_vld", 32'(bus.rd_valid_out), 32'd0);
    wait_drain("t3_zero");
    chk_status("t3_zero_end");

    // out-of-range write, then oversize image clamped to buffer
    step(0, 0, 0, 0, 0, 1);
    step(1, 16, 32'h55aa55aa, 0, 0, 0);
    chk_status("t4_oor");
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 32'h03020100, 0, 0, 0);
    step(0, 20, 0, 1, 0, 0);
    chk_status("t4_big");
    step(0, 0, 0, 1, 1, 0);
    wait_drain("t4_big");

    // clear mid-stream at byte 3
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 32'h03020100, 0, 0, 0);
    step(1, 4, 32'h07060504, 0, 0, 0);
    step(0, 8, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    idle(4);
    step(0, 0, 0, 0, 0, 1);
    chk("t5_clr_vld", 32'(bus.rd_valid_out), 32'd0);
    chk_status("t5_clr");

    // reset mid-stream with overflow pending
    step(1, 0, 32'h03020100, 0, 0, 0);
    step(0, 8, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, 0, 32'h0, 1, 0, 0);
    idle(2);
    chk("t5_pre_ovf", 32'(bus.overflow_out), 32'd1);
    reset = 1'b1;
    bus.image_valid_in = 1'b0;
    tick();
    model_reset();
    chk_zero_outs("t5_rst");
    reset = 1'b0;
    tick();

    // word written in the same cycle as the finishing edge
    step(1, 0, 32'h03020100, 0, 0, 0);
    step(1, 4, 32'h07060504, 0, 0, 0);
    step(1, 12, 32'hc3c2c1c0, 1, 0, 0);
    chk_status("t6");
    step(0, 0, 0, 1, 1, 0);
    wait_drain("t6");
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 32'h03020100, 0, 0, 0);
    step(0, 16, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    wait_drain("t6_full");

    // random images
    for (int it = 0; it < 40; it++) begin
      step(0, 0, 0, 0, 0, 1);
      if ($urandom_range(0, 3) == 0) step(0, 0, 0, 0, 1, 0);
      nw = $urandom_range(0, 4);
      repeat (nw) step(1, 4 * $urandom_range(0, 4), $urandom, 0, 0, 0);
      sz   = $urandom_range(0, 20);
      same = 1'($urandom_range(0, 1));
      step(same, sz, $urandom, 1, 0, 0);
      chk_status("rnd_fin");
      if ($urandom_range(0, 3) == 0) begin
        step(1, 4 * $urandom_range(0, 3), $urandom, 1, 0, 0);
        chk_status("rnd_late");
      end
      rmode = $urandom_range(0, 2);
      step(0, 0, 0, 1, 1, 0);
      wait_drain("rnd");
      rmode = 0;
      chk_status("rnd_end");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
